// File: rtl/asym_dual_port_ram_clr.sv
// Asymmetric single-clock dual-port RAM with a narrow CPU port (A) and a wide renderer port (B).
// Memory is filled with a constant after reset or on request. Reads see same-cycle writes.
module asym_dual_port_ram_clr #(
   parameter int                      ADDR_WIDTH_A = 11,
   parameter int                      DATA_WIDTH_A = 16,
   parameter int                      RATIO        = 2,
   parameter logic [DATA_WIDTH_A-1:0] INIT_VALUE   = {DATA_WIDTH_A{1'b0}}
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic                                     io_clear,
   output logic                                     io_busy,
   input  logic                                     io_portA_rd,
   input  logic                                     io_portA_wr,
   input  logic [ADDR_WIDTH_A-1:0]                  io_portA_addr,
   input  logic [DATA_WIDTH_A/8-1:0]                io_portA_mask,
   input  logic [DATA_WIDTH_A-1:0]                  io_portA_din,
   output logic [DATA_WIDTH_A-1:0]                  io_portA_dout,
   output logic                                     io_portA_valid,
   input  logic                                     io_portB_rd,
   input  logic                                     io_portB_wr,
   input  logic [ADDR_WIDTH_A-$clog2(RATIO)-1:0]    io_portB_addr,
   input  logic [DATA_WIDTH_A*RATIO/8-1:0]          io_portB_mask,
   input  logic [DATA_WIDTH_A*RATIO-1:0]            io_portB_din,
   output logic [DATA_WIDTH_A*RATIO-1:0]            io_portB_dout,
   output logic                                     io_portB_valid
);

   localparam int LOG_R        = $clog2(RATIO);
   localparam int DATA_WIDTH_B = DATA_WIDTH_A * RATIO;
   localparam int ADDR_WIDTH_B = ADDR_WIDTH_A - LOG_R;
   localparam int NBA          = DATA_WIDTH_A / 8;
   localparam int NBB          = DATA_WIDTH_B / 8;
   localparam int DEPTH_B      = 1 << ADDR_WIDTH_B;
   localparam int LANE_W       = (LOG_R > 0) ? LOG_R : 1;

   localparam logic [ADDR_WIDTH_B-1:0] LAST_WORD = {ADDR_WIDTH_B{1'b1}};
   localparam logic [DATA_WIDTH_B-1:0] INIT_WORD = {RATIO{INIT_VALUE}};

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   function automatic logic [DATA_WIDTH_B-1:0] bytes_to_bits(input logic [NBB-1:0] m);
      logic [DATA_WIDTH_B-1:0] b;
      b = {DATA_WIDTH_B{1'b0}};
      for (int i = 0; i < NBB; i++) begin
         b[i*8 +: 8] = {8{m[i]}};
      end
      return b;
   endfunction

   // Per byte: take new_d where m is set, otherwise keep old_d.
   function automatic logic [DATA_WIDTH_B-1:0] byte_merge(input logic [DATA_WIDTH_B-1:0] old_d,
                                                          input logic [DATA_WIDTH_B-1:0] new_d,
                                                          input logic [NBB-1:0]          m);
      logic [DATA_WIDTH_B-1:0] bits;
      bits = bytes_to_bits(m);
      return (old_d & ~bits) | (new_d & bits);
   endfunction

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH_B-1:0] cnt_q, cnt_d;

   logic                    ready_s;
   logic                    a_rd_s, a_wr_s, b_rd_s, b_wr_s;
   logic [ADDR_WIDTH_B-1:0] a_word_s;
   logic [LANE_W-1:0]       a_lane_s;
   logic                    same_word_s;
   logic [NBB-1:0]          a_wmask_s, b_wmask_s;
   logic [DATA_WIDTH_B-1:0] a_wdata_s;

   logic                    valid_a_q, valid_a_d, valid_b_q, valid_b_d;
   logic [LANE_W-1:0]       lane_a_q, lane_a_d;
   logic [NBB-1:0]          fwd_mask_a_q, fwd_mask_a_d, fwd_mask_b_q, fwd_mask_b_d;
   logic [DATA_WIDTH_B-1:0] fwd_data_a_q, fwd_data_a_d, fwd_data_b_q, fwd_data_b_d;
   logic [DATA_WIDTH_A-1:0] hold_a_q, hold_a_d;
   logic [DATA_WIDTH_B-1:0] hold_b_q, hold_b_d;

   logic [DATA_WIDTH_B-1:0] ram_q [DEPTH_B];
   logic [DATA_WIDTH_B-1:0] ram_rd_a_q, ram_rd_b_q;
   logic [DATA_WIDTH_B-1:0] merged_a_s, merged_b_s;

   if (LOG_R > 0) begin : g_lane
      assign a_lane_s = io_portA_addr[LOG_R-1:0];
   end else begin : g_no_lane
      assign a_lane_s = 1'b0;
   end

   assign io_busy = (state_q == ST_CLEAR);

   // Clear sequencer next state; io_clear restarts from word 0 in any state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (io_clear) begin
         state_d = ST_CLEAR;
         cnt_d   = {ADDR_WIDTH_B{1'b0}};
      end else begin
         case (state_q)
            ST_CLEAR: begin
               cnt_d = cnt_q + ADDR_WIDTH_B'(32'd1);
               if (cnt_q == LAST_WORD) begin
                  state_d = ST_READY;
               end else begin
                  state_d = ST_CLEAR;
               end
            end
            ST_READY: begin
               state_d = ST_READY;
            end
            default: begin
               state_d = ST_CLEAR;
               cnt_d   = {ADDR_WIDTH_B{1'b0}};
            end
         endcase
      end
   end

   // Request qualification, wide-word write masks and forwarding payloads.
   always_comb begin
      ready_s     = (state_q == ST_READY);
      a_rd_s      = ready_s & io_portA_rd;
      a_wr_s      = ready_s & io_portA_wr;
      b_rd_s      = ready_s & io_portB_rd;
      b_wr_s      = ready_s & io_portB_wr;
      a_word_s    = io_portA_addr[ADDR_WIDTH_A-1:LOG_R];
      same_word_s = (a_word_s == io_portB_addr);
      a_wdata_s   = {RATIO{io_portA_din}};
      if (a_wr_s) begin
         a_wmask_s = NBB'(io_portA_mask) << (a_lane_s * NBA);
      end else begin
         a_wmask_s = {NBB{1'b0}};
      end
      if (b_wr_s) begin
         b_wmask_s = io_portB_mask;
      end else begin
         b_wmask_s = {NBB{1'b0}};
      end
      valid_a_d = a_rd_s;
      valid_b_d = b_rd_s;
      lane_a_d  = a_lane_s;
      // Port A bytes take priority when both ports hit the same wide word.
      if (same_word_s) begin
         fwd_mask_a_d = a_wmask_s | b_wmask_s;
         fwd_mask_b_d = a_wmask_s | b_wmask_s;
         fwd_data_b_d = byte_merge(io_portB_din, a_wdata_s, a_wmask_s);
      end else begin
         fwd_mask_a_d = a_wmask_s;
         fwd_mask_b_d = b_wmask_s;
         fwd_data_b_d = io_portB_din;
      end
      fwd_data_a_d = byte_merge(io_portB_din, a_wdata_s, a_wmask_s);
   end

   // Read outputs: pre-write RAM data patched with the bytes written in the request cycle.
   always_comb begin
      merged_a_s = byte_merge(ram_rd_a_q, fwd_data_a_q, fwd_mask_a_q);
      merged_b_s = byte_merge(ram_rd_b_q, fwd_data_b_q, fwd_mask_b_q);
      if (valid_a_q) begin
         io_portA_dout = DATA_WIDTH_A'(merged_a_s >> (lane_a_q * DATA_WIDTH_A));
      end else begin
         io_portA_dout = hold_a_q;
      end
      if (valid_b_q) begin
         io_portB_dout = merged_b_s;
      end else begin
         io_portB_dout = hold_b_q;
      end
      io_portA_valid = valid_a_q;
      io_portB_valid = valid_b_q;
      hold_a_d       = io_portA_dout;
      hold_b_d       = io_portB_dout;
   end

   // Control and output-holding registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_CLEAR;
         cnt_q        <= {ADDR_WIDTH_B{1'b0}};
         valid_a_q    <= 1'b0;
         valid_b_q    <= 1'b0;
         lane_a_q     <= {LANE_W{1'b0}};
         fwd_mask_a_q <= {NBB{1'b0}};
         fwd_mask_b_q <= {NBB{1'b0}};
         fwd_data_a_q <= {DATA_WIDTH_B{1'b0}};
         fwd_data_b_q <= {DATA_WIDTH_B{1'b0}};
         hold_a_q     <= {DATA_WIDTH_A{1'b0}};
         hold_b_q     <= {DATA_WIDTH_B{1'b0}};
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         valid_a_q    <= valid_a_d;
         valid_b_q    <= valid_b_d;
         lane_a_q     <= lane_a_d;
         fwd_mask_a_q <= fwd_mask_a_d;
         fwd_mask_b_q <= fwd_mask_b_d;
         fwd_data_a_q <= fwd_data_a_d;
         fwd_data_b_q <= fwd_data_b_d;
         hold_a_q     <= hold_a_d;
         hold_b_q     <= hold_b_d;
      end
   end

   // Block RAM: byte-masked writes (A written last so it wins) and registered read-before-write.
   always_ff @(posedge clock) begin
      if (state_q == ST_CLEAR) begin
         ram_q[cnt_q] <= INIT_WORD;
      end else begin
         for (int i = 0; i < NBB; i++) begin
            if (b_wmask_s[i]) begin
               ram_q[io_portB_addr][i*8 +: 8] <= io_portB_din[i*8 +: 8];
            end
         end
         for (int i = 0; i < NBB; i++) begin
            if (a_wmask_s[i]) begin
               ram_q[a_word_s][i*8 +: 8] <= a_wdata_s[i*8 +: 8];
            end
         end
      end
      if (a_rd_s) begin
         ram_rd_a_q <= ram_q[a_word_s];
      end else begin
         ram_rd_a_q <= ram_rd_a_q;
      end
      if (b_rd_s) begin
         ram_rd_b_q <= ram_q[io_portB_addr];
      end else begin
         ram_rd_b_q <= ram_rd_b_q;
      end
   end

endmodule

// File: tb/tb_asym_dual_port_ram_clr.sv
// Bench for asym_dual_port_ram_clr: default instance checked against a narrow-word array model,
// plus a RATIO=4 / INIT_VALUE=0xFFFF instance for the fill pattern.
module tb_asym_dual_port_ram_clr;

   logic        clock;
   logic        reset;
   logic        io_clear;
   logic        io_busy;
   logic        a_rd, a_wr, a_valid;
   logic [10:0] a_addr;
   logic [1:0]  a_mask;
   logic [15:0] a_din, a_dout;
   logic        b_rd, b_wr, b_valid;
   logic [9:0]  b_addr;
   logic [3:0]  b_mask;
   logic [31:0] b_din, b_dout;

   logic        clr2, busy2;
   logic        a2_rd, a2_wr, a2_valid;
   logic [10:0] a2_addr;
   logic [1:0]  a2_mask;
   logic [15:0] a2_din, a2_dout;
   logic        b2_rd, b2_wr, b2_valid;
   logic [8:0]  b2_addr;
   logic [7:0]  b2_mask;
   logic [63:0] b2_din, b2_dout;

   int          checks;
   int          errors;
   logic [15:0] model [2048];
   logic        bench_busy;
   logic [15:0] exp_da;
   logic [31:0] exp_db;

   asym_dual_port_ram_clr dut (
      .clock(clock), .reset(reset), .io_clear(io_clear), .io_busy(io_busy),
      .io_portA_rd(a_rd), .io_portA_wr(a_wr), .io_portA_addr(a_addr), .io_portA_mask(a_mask),
      .io_portA_din(a_din), .io_portA_dout(a_dout), .io_portA_valid(a_valid),
      .io_portB_rd(b_rd), .io_portB_wr(b_wr), .io_portB_addr(b_addr), .io_portB_mask(b_mask),
      .io_portB_din(b_din), .io_portB_dout(b_dout), .io_portB_valid(b_valid)
   );

   asym_dual_port_ram_clr #(.ADDR_WIDTH_A(11), .DATA_WIDTH_A(16), .RATIO(4), .INIT_VALUE(16'hFFFF)) dut4 (
      .clock(clock), .reset(reset), .io_clear(clr2), .io_busy(busy2),
      .io_portA_rd(a2_rd), .io_portA_wr(a2_wr), .io_portA_addr(a2_addr), .io_portA_mask(a2_mask),
      .io_portA_din(a2_din), .io_portA_dout(a2_dout), .io_portA_valid(a2_valid),
      .io_portB_rd(b2_rd), .io_portB_wr(b2_wr), .io_portB_addr(b2_addr), .io_portB_mask(b2_mask),
      .io_portB_din(b2_din), .io_portB_dout(b2_dout), .io_portB_valid(b2_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock of traffic on the default instance. The model applies B bytes, then A bytes
   // (A wins), and reads return the contents after this cycle's writes.
   task automatic cyc(input logic ard, input logic awr, input logic [10:0] aa, input logic [1:0] am,
                      input logic [15:0] ad, input logic brd, input logic bwr, input logic [9:0] ba,
                      input logic [3:0] bm, input logic [31:0] bd);
      int idx;
      a_rd = ard; a_wr = awr; a_addr = aa; a_mask = am; a_din = ad;
      b_rd = brd; b_wr = bwr; b_addr = ba; b_mask = bm; b_din = bd;
      if (!bench_busy) begin
         if (bwr) begin
            for (int n = 0; n < 4; n++) begin
               idx = int'(ba) * 2 + n / 2;
               if (bm[n]) model[idx][(n % 2) * 8 +: 8] = bd[n * 8 +: 8];
            end
         end
         if (awr) begin
            for (int n = 0; n < 2; n++) begin
               if (am[n]) model[aa][n * 8 +: 8] = ad[n * 8 +: 8];
            end
         end
         if (ard) exp_da = model[aa];
         if (brd) exp_db = {model[int'(ba) * 2 + 1], model[int'(ba) * 2]};
      end
      @(posedge clock); #1;
      a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
      chk("a_valid", 64'(a_valid), 64'(ard && !bench_busy));
      chk("b_valid", 64'(b_valid), 64'(brd && !bench_busy));
      chk("a_dout", 64'(a_dout), 64'(exp_da));
      chk("b_dout", 64'(b_dout), 64'(exp_db));
   endtask

   task automatic cyc_random(input bit local_addr);
      logic [10:0] aa;
      logic [9:0]  ba;
      aa = local_addr ? 11'($urandom_range(0, 15)) : 11'($urandom);
      ba = local_addr ? 10'($urandom_range(0, 7))  : 10'($urandom);
      cyc(rbit(), rbit(), aa, 2'($urandom), 16'($urandom),
          rbit(), rbit(), ba, 4'($urandom), $urandom);
   endtask

   // n cycles of ignored traffic while clearing; if last, busy must drop on the final one.
   task automatic clear_phase(input int n, input bit last);
      for (int k = 1; k <= n; k++) begin
         cyc_random(1'b1);
         chk("busy_clear", 64'(io_busy), 64'((last && k == n) ? 1'b0 : 1'b1));
      end
      if (last) begin
         bench_busy = 1'b0;
         foreach (model[i]) model[i] = 16'h0000;
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      bench_busy = 1'b1; exp_da = 16'h0000; exp_db = 32'h0000_0000;
      foreach (model[i]) model[i] = 16'h0000;
      reset = 1'b1; io_clear = 1'b0; clr2 = 1'b0;
      a_rd = 1'b0; a_wr = 1'b0; a_addr = 11'd0; a_mask = 2'b00; a_din = 16'h0;
      b_rd = 1'b0; b_wr = 1'b0; b_addr = 10'd0; b_mask = 4'b0; b_din = 32'h0;
      a2_rd = 1'b0; a2_wr = 1'b0; a2_addr = 11'd0; a2_mask = 2'b00; a2_din = 16'h0;
      b2_rd = 1'b0; b2_wr = 1'b0; b2_addr = 9'd0; b2_mask = 8'h00; b2_din = 64'h0;

      repeat (3) begin @(posedge clock); #1; end
      chk("rst_busy", 64'(io_busy), 64'd1);
      chk("rst_a_valid", 64'(a_valid), 64'd0);
      chk("rst_b_valid", 64'(b_valid), 64'd0);
      chk("rst_a_dout", 64'(a_dout), 64'd0);
      chk("rst_b_dout", 64'(b_dout), 64'd0);
      chk("rst_busy4", 64'(busy2), 64'd1);
      reset = 1'b0;

      // Initial clear: 1024 busy cycles for the default part, 512 for RATIO=4.
      for (int k = 1; k <= 1024; k++) begin
         cyc_random(1'b0);
         chk("busy_init", 64'(io_busy), 64'(k < 1024));
         if (k == 511) chk("busy4_511", 64'(busy2), 64'd1);
         if (k == 512) chk("busy4_512", 64'(busy2), 64'd0);
      end
      bench_busy = 1'b0;
      foreach (model[i]) model[i] = 16'h0000;

      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, 11'($urandom), 2'b00, 16'h0, 1'b1, 1'b0, 10'($urandom), 4'h0, 32'h0);
         chk("post_clr_a", 64'(a_dout), 64'h0);
         chk("post_clr_b", 64'(b_dout), 64'h0);
      end

      a2_rd = 1'b1; a2_addr = 11'h7FF; b2_rd = 1'b1; b2_addr = 9'd0;
      @(posedge clock); #1;
      chk("r4_b_word0", b2_dout, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("r4_b_valid", 64'(b2_valid), 64'd1);
      chk("r4_a_last", 64'(a2_dout), 64'hFFFF);
      a2_rd = 1'b0; b2_addr = 9'h1FF;
      @(posedge clock); #1;
      chk("r4_b_last", b2_dout, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("r4_a_valid_off", 64'(a2_valid), 64'd0);
      b2_rd = 1'b0;

      cyc(1'b0, 1'b1, 11'd0, 2'b11, 16'h1234, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
      cyc(1'b0, 1'b1, 11'd1, 2'b11, 16'hABCD, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
      cyc(1'b0, 1'b0, 11'd0, 2'b00, 16'h0, 1'b1, 1'b0, 10'd0, 4'h0, 32'h0);
      chk("tp_b_rd0", 64'(b_dout), 64'hABCD1234);
      cyc(1'b0, 1'b0, 11'd0, 2'b00, 16'h0, 1'b0, 1'b1, 10'd5, 4'b0011, 32'hDEADBEEF);
      cyc(1'b1, 1'b0, 11'd10, 2'b00, 16'h0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
      chk("tp_a_rd10", 64'(a_dout), 64'hBEEF);
      cyc(1'b1, 1'b0, 11'd11, 2'b00, 16'h0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
      chk("tp_a_rd11", 64'(a_dout), 64'h0000);
      cyc(1'b0, 1'b1, 11'd4, 2'b01, 16'h5555, 1'b0, 1'b1, 10'd2, 4'b1111, 32'h11223344);
      cyc(1'b0, 1'b0, 11'd0, 2'b00, 16'h0, 1'b1, 1'b0, 10'd2, 4'h0, 32'h0);
      chk("tp_merge", 64'(b_dout), 64'h11223355);
      cyc(1'b1, 1'b1, 11'd6, 2'b11, 16'h7777, 1'b1, 1'b0, 10'd3, 4'h0, 32'h0);
      chk("tp_fwd_b", 64'(b_dout[15:0]), 64'h7777);
      chk("tp_rdwr_a", 64'(a_dout), 64'h7777);
      cyc(1'b0, 1'b0, 11'd0, 2'b00, 16'h0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
      chk("hold_a", 64'(a_dout), 64'h7777);

      for (int i = 0; i < 400; i++) cyc_random(($urandom_range(0, 3) != 0));

      io_clear = 1'b1;
      cyc(1'b0, 1'b0, 11'd0, 2'b00, 16'h0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
      io_clear = 1'b0;
      chk("clr_busy_rise", 64'(io_busy), 64'd1);
      bench_busy = 1'b1;
      clear_phase(500, 1'b0);
      io_clear = 1'b1;
      cyc_random(1'b1);
      io_clear = 1'b0;
      chk("clr_restart_busy", 64'(io_busy), 64'd1);
      clear_phase(1024, 1'b1);

      for (int w = 0; w < 1024; w++) begin
         cyc(1'b0, 1'b0, 11'd0, 2'b00, 16'h0, 1'b1, 1'b0, 10'(w), 4'h0, 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
